// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the EX stage: {remainder, quotient} after DW steps.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterative path via DZERO.
module div_unit #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o,
  output logic            stallreq_o
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DZERO = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [DW-1:0]     dividend_r;
  logic [DW-1:0]     dvs_r;
  logic [DW-1:0]     rem_r;
  logic [DW-1:0]     quo_r;
  logic              neg_q_r;
  logic              neg_r_r;
  logic              dz_r;
  logic [2*DW-1:0]   result_r;
  logic              ready_r;

  logic [DW:0]       shifted_s;
  logic [DW:0]       diff_s;
  logic [DW-1:0]     rem_nxt_s;
  logic [DW-1:0]     quo_nxt_s;
  logic [DW-1:0]     rem_fix_s;
  logic [DW-1:0]     quo_fix_s;
  logic [DW-1:0]     mag1_s;
  logic [DW-1:0]     mag2_s;
  logic              zero_s;
  logic              stall_s;

  // Operand magnitudes and zero-divisor detection at the point of capture.
  always_comb begin
    mag1_s = opdata1_i;
    mag2_s = opdata2_i;
    if (signed_i && opdata1_i[DW-1]) begin
      mag1_s = -opdata1_i;
    end else begin
      mag1_s = opdata1_i;
    end
    if (signed_i && opdata2_i[DW-1]) begin
      mag2_s = -opdata2_i;
    end else begin
      mag2_s = opdata2_i;
    end
    zero_s = (opdata2_i == {DW{1'b0}});
  end

  // One restoring step; the partial remainder never exceeds the divisor, so DW bits suffice.
  always_comb begin
    shifted_s = {rem_r, quo_r[DW-1]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    rem_nxt_s = {rem_r[DW-2:0], quo_r[DW-1]};
    quo_nxt_s = {quo_r[DW-2:0], 1'b0};
    if (!diff_s[DW]) begin
      rem_nxt_s = diff_s[DW-1:0];
      quo_nxt_s = {quo_r[DW-2:0], 1'b1};
    end else begin
      rem_nxt_s = {rem_r[DW-2:0], quo_r[DW-1]};
      quo_nxt_s = {quo_r[DW-2:0], 1'b0};
    end
    if (neg_q_r) begin
      quo_fix_s = -quo_nxt_s;
    end else begin
      quo_fix_s = quo_nxt_s;
    end
    if (neg_r_r) begin
      rem_fix_s = -rem_nxt_s;
    end else begin
      rem_fix_s = rem_nxt_s;
    end
  end

  // Stall the pipeline while a divide is being requested or in flight; annul drops it at once.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:        stall_s = start_i & ~annul_i;
      BUSY, DZERO: stall_s = ~annul_i;
      default:     stall_s = 1'b0;
    endcase
    if (!rst) begin
      stall_s = 1'b0;
    end else begin
      stall_s = stall_s;
    end
  end

  // Control FSM with operand capture, iteration and registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      dividend_r <= {DW{1'b0}};
      dvs_r      <= {DW{1'b0}};
      rem_r      <= {DW{1'b0}};
      quo_r      <= {DW{1'b0}};
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dz_r       <= 1'b0;
      result_r   <= {(2*DW){1'b0}};
      ready_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ready_r <= 1'b0;
          if (start_i && !annul_i) begin
            dividend_r <= opdata1_i;
            dvs_r      <= mag2_s;
            quo_r      <= mag1_s;
            rem_r      <= {DW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            neg_q_r    <= signed_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
            neg_r_r    <= signed_i & opdata1_i[DW-1];
            dz_r       <= zero_s;
`ifdef DIV_ZERO_FAST_EN
            state_r    <= zero_s ? DZERO : BUSY;
`else
            state_r    <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (annul_i) begin
            state_r <= IDLE;
          end else begin
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CW'(DW - 1)) begin
              state_r  <= DONE;
              ready_r  <= 1'b1;
              result_r <= dz_r ? {dividend_r, {DW{1'b1}}} : {rem_fix_s, quo_fix_s};
            end
          end
        end
        DZERO: begin
          if (annul_i) begin
            state_r <= IDLE;
          end else begin
            state_r  <= DONE;
            ready_r  <= 1'b1;
            result_r <= {dividend_r, {DW{1'b1}}};
          end
        end
        DONE: begin
          ready_r <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ready_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign result_o   = result_r;
  assign ready_o    = ready_r;
  assign stallreq_o = stall_s;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter DW, default 32, operand width in bits.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  EX-stage divide request, held high by EX until completion.
REQ-005 signed_i  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start_i.
REQ-006 opdata1_i  input  DW  dividend; sampled with start_i.
REQ-007 opdata2_i  input  DW  divisor; sampled with start_i.
REQ-008 annul_i  input  1  cancel the in-flight divide (EX flush).
REQ-009 result_o  output  2*DW  {remainder, quotient}; valid only while ready_o=1.
REQ-010 ready_o  output  1  one-cycle result-valid pulse.
REQ-011 stallreq_o  output  1  stall request; drives CTRL stallreq_for_ex.

Function
REQ-012 The FSM SHALL have four states: IDLE, BUSY, DZERO, DONE.
REQ-013 In IDLE with start_i=1 and annul_i=0, the block SHALL latch the operands, clear the iteration counter and go to BUSY, or to DZERO per REQ-024.
REQ-014 BUSY SHALL perform one restoring shift-subtract step per cycle on operand magnitudes for exactly DW cycles, then go to DONE.
REQ-015 DONE SHALL last exactly one cycle, assert ready_o=1 with result_o valid, then return unconditionally to IDLE; start_i is ignored in DONE.
REQ-016 stallreq_o SHALL be combinational: 1 when (IDLE and start_i and not annul_i), or in BUSY, or in DZERO; 0 in DONE and otherwise.
REQ-017 Latency: for a start sampled at edge N, ready_o SHALL be high in cycle N+DW+1 (cycle 33 for DW=32), and stallreq_o low in that same cycle.
REQ-018 Signed mode: quotient SHALL be negated when operand signs differ; remainder SHALL take the dividend's sign.
REQ-019 Signed -2^(DW-1) / -1 SHALL yield quotient 2^(DW-1) (wraps) and remainder 0; no trap.
REQ-020 Divisor zero, any mode: result_o SHALL be quotient all-ones and remainder = latched dividend.
REQ-021 annul_i=1 in BUSY or DZERO SHALL return the FSM to IDLE at the next edge, with no ready_o pulse; stallreq_o SHALL drop in that same cycle.
REQ-022 Back-to-back divides: a start in the IDLE cycle that follows DONE SHALL begin a new operation with no lost cycles.
REQ-023 Operand changes while the FSM is not in IDLE SHALL have no effect on the result.

Configuration
REQ-024 With macro DIV_ZERO_FAST_EN defined, a zero divisor SHALL go IDLE->DZERO->DONE, giving ready_o two cycles after start (stall lasts 2 cycles). Without the macro, a zero divisor SHALL traverse BUSY with the full DW+1 latency. In both builds the result values SHALL follow REQ-020.

Reset
REQ-025 With rst=0 the FSM SHALL go to IDLE asynchronously. result_o, ready_o, the counter and the operand registers SHALL reset to 0, and stallreq_o SHALL be 0 regardless of start_i.
REQ-026 Reset asserted mid-BUSY SHALL abort the operation. After release, the first edge with start_i=1 SHALL start a fresh divide.

Verification
REQ-027 Unsigned 100/7, start at edge 0 -> stallreq_o high for cycles 0..32, ready_o high in cycle 33 only, result_o={32'd2,32'd14}.
REQ-028 Signed -7/2 -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF; signed 7/-2 -> quotient 32'hFFFFFFFD, remainder 32'd1.
REQ-029 Signed 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0, latency 33.
REQ-030 Divide 5/0 -> result_o={32'd5,32'hFFFFFFFF}, ready_o in cycle 2 with DIV_ZERO_FAST_EN defined, in cycle 33 without it.
REQ-031 annul_i pulsed in cycle 10 of BUSY -> stallreq_o=0 from cycle 10, no ready_o pulse; a following 9/3 returns quotient 3, remainder 0.
REQ-032 rst asserted in cycle 15 of BUSY -> all outputs 0 immediately, state IDLE; after release, 20/4 gives quotient 5 with latency 33.
